move_scheduler: RTL

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler_pkg.sv | 56 +++++
 rtl/move_scheduler_sync.sv | 30 +++
 rtl/move_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/move_scheduler_pkg.sv
// Shared key codes, command encodings and timing limits for move_scheduler.
// Optional build macro: MOVE_SCHEDULER_AUTOREPEAT_EN.
package move_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_7 = 4'h7;

    localparam logic [2:0] STAT_MOVE_DOWN   = 3'b100;
    localparam logic [2:0] STAT_MOVE_LEFT   = 3'b101;
    localparam logic [2:0] STAT_MOVE_RIGHT  = 3'b110;
    localparam logic [2:0] STAT_MOVE_ROTATE = 3'b111;
    localparam logic [2:0] STAT_ADD_LINE    = 3'b010;

    localparam logic [2:0] OP_NONE    = 3'b000;
    localparam logic [2:0] OP_DOWN    = STAT_MOVE_DOWN;
    localparam logic [2:0] OP_LEFT    = STAT_MOVE_LEFT;
    localparam logic [2:0] OP_RIGHT   = STAT_MOVE_RIGHT;
    localparam logic [2:0] OP_ROTATE  = STAT_MOVE_ROTATE;
    localparam logic [2:0] OP_ADDLINE = STAT_ADD_LINE;

    localparam logic [2:0] GARB_MAX = 3'd7;

    localparam int WDOG_W = 9;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 9'd511;

    localparam int AREP_W = 23;
    localparam logic [AREP_W-1:0] AREP_PERIOD = 23'd8_000_000;

    typedef struct packed {
        logic       vld;
        logic [2:0] op;
    } key_map_t;

    function automatic key_map_t map_key(input logic [3:0] key);
        key_map_t m;
        m.vld = 1'b1;
        m.op  = OP_NONE;
        case (key)
            KEY_4:   m.op = OP_DOWN;
            KEY_1:   m.op = OP_LEFT;
            KEY_7:   m.op = OP_RIGHT;
            KEY_0:   m.op = OP_ROTATE;
            default: m.vld = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/move_scheduler_sync.sv
// sync_edge_det: 2-flop synchronizer for an asynchronous level plus a
// single-cycle rising-edge pulse in the destination clock domain.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates gravity, keypad and garbage-line requests into one command
// stream. Optional build macro: MOVE_SCHEDULER_AUTOREPEAT_EN.
module move_scheduler
    import move_scheduler_pkg::*;
(
    input  logic       clk_40M,
    input  logic       rst,
    input  logic       clk_1,
    input  logic [3:0] pad_key,
    input  logic       pad_pressed,
    input  logic       game_addLine,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    input  logic       cmd_ok,
    output logic       piece_lock,
    output logic [2:0] garbage_cnt,
    output logic       err_timeout
);

    state_e state_q;
    state_e state_d;

    logic [2:0]        cmd_op_q, cmd_op_d;
    logic              grav_pend_q, grav_pend_d;
    logic              key_vld_q, key_vld_d;
    logic [2:0]        key_op_q, key_op_d;
    logic [2:0]        garb_q, garb_d;
    logic              lock_seen_q, lock_seen_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              lock_q, lock_d;
    logic              tmo_q, tmo_d;

    logic grav_rise;
    logic grav_lvl_unused;
    logic press_rise;
    logic pad_lvl;

    logic take_add, take_grav, take_key;
    logic sel_vld;
    logic dec;

    key_map_t   pk;
    logic       key_set;
    logic [2:0] key_set_op;

    sync_edge_det u_grav_sync (
        .clk_i   (clk_40M),
        .rst_i   (rst),
        .d_i     (clk_1),
        .level_o (grav_lvl_unused),
        .rise_o  (grav_rise)
    );

    sync_edge_det u_pad_sync (
        .clk_i   (clk_40M),
        .rst_i   (rst),
        .d_i     (pad_pressed),
        .level_o (pad_lvl),
        .rise_o  (press_rise)
    );

    assign pk = map_key(pad_key);

`ifdef MOVE_SCHEDULER_AUTOREPEAT_EN
    logic [AREP_W-1:0] rep_cnt_q;
    logic [2:0]        rep_op_q;
    logic              rep_arm_q;
    logic              rep_fire;

    // Period is measured from the original press, then from each re-latch.
    assign rep_fire = rep_arm_q & pad_lvl & ~press_rise
                    & (rep_cnt_q == AREP_PERIOD - 23'd1);

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_op_q  <= OP_NONE;
            rep_arm_q <= 1'b0;
        end else if (press_rise) begin
            rep_cnt_q <= '0;
            rep_op_q  <= pk.op;
            rep_arm_q <= pk.vld;
        end else if (!pad_lvl) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else if (rep_arm_q) begin
            rep_cnt_q <= rep_fire ? '0 : rep_cnt_q + 23'd1;
        end
    end

    assign key_set    = (press_rise & pk.vld) | rep_fire;
    assign key_set_op = press_rise ? pk.op : rep_op_q;
`else
    logic pad_lvl_unused;
    assign pad_lvl_unused = pad_lvl;
    assign key_set        = press_rise & pk.vld;
    assign key_set_op     = pk.op;
`endif

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_vld) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (cmd_done || wdog_q == WDOG_LIMIT) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        take_add  = 1'b0;
        take_grav = 1'b0;
        take_key  = 1'b0;
        cmd_op_d  = cmd_op_q;
        lock_d    = 1'b0;
        tmo_d     = 1'b0;
        dec       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                priority case (1'b1)
                    (garb_q != 3'd0) && lock_seen_q: begin
                        take_add = 1'b1;
                        cmd_op_d = OP_ADDLINE;
                    end
                    grav_pend_q: begin
                        take_grav = 1'b1;
                        cmd_op_d  = OP_DOWN;
                    end
                    key_vld_q: begin
                        take_key = 1'b1;
                        cmd_op_d = key_op_q;
                    end
                    default: ;
                endcase
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
            end
            ST_WAIT_DONE: begin
                if (cmd_done) begin
                    lock_d = (cmd_op_q == OP_DOWN) & ~cmd_ok;
                    dec    = (cmd_op_q == OP_ADDLINE);
                end else if (wdog_q == WDOG_LIMIT) begin
                    tmo_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign sel_vld = take_add | take_grav | take_key;

    // New arrivals win over the clear of the source being issued.
    always_comb begin
        grav_pend_d = grav_rise | (grav_pend_q & ~take_grav);

        key_vld_d = key_vld_q & ~take_key;
        key_op_d  = key_op_q;
        if (key_set) begin
            key_vld_d = 1'b1;
            key_op_d  = key_set_op;
        end

        garb_d = garb_q;
        unique case ({game_addLine, dec})
            2'b10:   if (garb_q != GARB_MAX) garb_d = garb_q + 3'd1;
            2'b01:   if (garb_q != 3'd0) garb_d = garb_q - 3'd1;
            default: ;
        endcase

        lock_seen_d = lock_seen_q;
        if (lock_d) begin
            lock_seen_d = 1'b1;
        end else if (dec && garb_d == 3'd0) begin
            lock_seen_d = 1'b0;
        end

        wdog_d = (state_q == ST_WAIT_DONE) ? wdog_q + 9'd1 : '0;
    end

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            cmd_op_q    <= OP_NONE;
            grav_pend_q <= 1'b0;
            key_vld_q   <= 1'b0;
            key_op_q    <= OP_NONE;
            garb_q      <= 3'd0;
            lock_seen_q <= 1'b0;
            wdog_q      <= '0;
            lock_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            cmd_op_q    <= cmd_op_d;
            grav_pend_q <= grav_pend_d;
            key_vld_q   <= key_vld_d;
            key_op_q    <= key_op_d;
            garb_q      <= garb_d;
            lock_seen_q <= lock_seen_d;
            wdog_q      <= wdog_d;
            lock_q      <= lock_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_op      = cmd_op_q;
    assign piece_lock  = lock_q;
    assign err_timeout = tmo_q;
    assign garbage_cnt = garb_q;

endmodule
